// File: rtl/lat_credit_buffer.sv
// Credit-gated reorder-free buffer sitting behind a fixed-latency, unstallable pipeline.
// Optional same-cycle bypass of an empty buffer: define LAT_CREDIT_BUFFER_FALLTHROUGH_EN.
module lat_credit_buffer #(
  parameter int DataWidth = 32,
  parameter int Depth     = 4,
  parameter int CntWidth  = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 issue_valid_i,
  output logic                 issue_ready_o,
  input  logic                 rsp_valid_i,
  input  logic [DataWidth-1:0] rsp_data_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [CntWidth-1:0]  credits_o,
  output logic                 overflow_o
);

  if (Depth < 1) begin : g_depth_chk
    $error("lat_credit_buffer: Depth must be >= 1");
  end

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
  localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);

  logic [CntWidth-1:0]  credits_q, credits_d;
  logic [CntWidth-1:0]  fill_q, fill_d;
  logic [PtrWidth-1:0]  wptr_q, wptr_d;
  logic [PtrWidth-1:0]  rptr_q, rptr_d;
  logic                 overflow_q, overflow_d;
  logic [DataWidth-1:0] mem_q [Depth];

  logic empty, full, issue, pop, rd, wr, drop, bypass;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  assign empty         = (fill_q == '0);
  assign full          = (fill_q == DepthCnt);
  assign issue_ready_o = (credits_q != '0);
  assign issue         = issue_valid_i && issue_ready_o;
  assign credits_o     = credits_q;
  assign overflow_o    = overflow_q;

`ifdef LAT_CREDIT_BUFFER_FALLTHROUGH_EN
  // An empty buffer forwards the arriving response straight to the consumer.
  assign bypass  = rsp_valid_i && empty;
  assign valid_o = !empty || bypass;
  assign data_o  = empty ? rsp_data_i : mem_q[rptr_q];
`else
  assign bypass  = 1'b0;
  assign valid_o = !empty;
  assign data_o  = mem_q[rptr_q];
`endif

  assign pop  = valid_o && ready_i;
  assign rd   = pop && !empty;
  // A full buffer still accepts a response when the head leaves in the same cycle.
  assign wr   = rsp_valid_i && !(bypass && ready_i) && (!full || rd);
  assign drop = rsp_valid_i && full && !rd;

  always_comb begin
    credits_d  = credits_q;
    fill_d     = fill_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q || drop;

    if (issue && !pop) begin
      credits_d = credits_q - CntWidth'(1);
    end else if (pop && !issue && (credits_q != DepthCnt)) begin
      credits_d = credits_q + CntWidth'(1);
    end

    if (wr && !rd) begin
      fill_d = fill_q + CntWidth'(1);
    end else if (rd && !wr) begin
      fill_d = fill_q - CntWidth'(1);
    end

    if (wr) wptr_d = next_ptr(wptr_q);
    if (rd) rptr_d = next_ptr(rptr_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credits_q  <= DepthCnt;
      fill_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      fill_q     <= fill_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by fill_q alone.
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q] <= rsp_data_i;
  end

endmodule

// File: tb/tb_lat_credit_buffer.sv
// Randomised and directed bench for lat_credit_buffer against a queue-based reference model.
module tb_lat_credit_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        iv4, irdy4, rv4, v4, r4, of4;
  logic [31:0] rd4, d4;
  logic [2:0]  cr4;

  logic        iv3, irdy3, rv3, v3, r3, of3;
  logic [31:0] rd3, d3;
  logic [1:0]  cr3;

  lat_credit_buffer #(.DataWidth(32), .Depth(4)) u4 (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(iv4), .issue_ready_o(irdy4),
    .rsp_valid_i(rv4), .rsp_data_i(rd4), .valid_o(v4), .ready_i(r4),
    .data_o(d4), .credits_o(cr4), .overflow_o(of4));

  lat_credit_buffer #(.DataWidth(32), .Depth(3)) u3 (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(iv3), .issue_ready_o(irdy3),
    .rsp_valid_i(rv3), .rsp_data_i(rd3), .valid_o(v3), .ready_i(r3),
    .data_o(d3), .credits_o(cr3), .overflow_o(of3));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model for the Depth=4 instance
  localparam int D4 = 4;
  logic [31:0] mq[$];
  int          mcred = D4;
  bit          mof = 1'b0;
  logic [31:0] popped[$];
  int          n_iss;
  logic        last_v;
  logic [31:0] last_d;

  task automatic step4();
    bit ev, was_empty, pop, iss;
    @(negedge clk);
    if (rst) begin
      mq.delete();
      mcred = D4;
      mof   = 1'b0;
    end else begin
      was_empty = (mq.size() == 0);
      ev = !was_empty;
`ifdef LAT_CREDIT_BUFFER_FALLTHROUGH_EN
      if (was_empty && rv4) ev = 1'b1;
`endif
      check("issue_ready", irdy4, mcred != 0);
      check("valid", v4, ev);
      if (ev) check("data", d4, was_empty ? rd4 : mq[0]);
      check("credits", cr4, mcred);
      check("overflow", of4, mof);
      last_v = v4;
      last_d = d4;
      if (v4 && r4) popped.push_back(d4);
      if (iv4 && irdy4) n_iss++;
      pop = ev && r4;
      iss = iv4 && (mcred != 0);
      if (pop && !was_empty) void'(mq.pop_front());
      if (rv4 && !(pop && was_empty)) begin
        if (mq.size() < D4) mq.push_back(rd4);
        else mof = 1'b1;
      end
      mcred = mcred + int'(pop) - int'(iss);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle4();
    iv4 = 1'b0; rv4 = 1'b0; r4 = 1'b0; rd4 = '0;
  endtask

  task automatic do_reset();
    idle4();
    iv3 = 1'b0; rv3 = 1'b0; r3 = 1'b0; rd3 = '0;
    rst = 1'b1;
    step4();
    step4();
    rst = 1'b0;
  endtask

  task automatic fill_full4(input logic [31:0] base);
    iv4 = 1'b1;
    repeat (4) step4();
    iv4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rv4 = 1'b1; rd4 = base + 32'(i);
      step4();
    end
    rv4 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        pv [2];
    logic [31:0] pd [2];
    logic        iss;
    logic        pend_v;
    logic [31:0] pend_d;
    logic [31:0] got3[$];
    int          issued;

    do_reset();

    // Issue pressure with no responses: exactly Depth launches
    n_iss = 0;
    iv4 = 1'b1;
    repeat (6) step4();
    check("issue_count", n_iss, 4);
    check("credits_zero", cr4, 0);
    iv4 = 1'b0;

    // Four responses then in-order drain
    for (int i = 0; i < 4; i++) begin
      rv4 = 1'b1; rd4 = 32'hA0 + 32'(i);
      step4();
    end
    rv4 = 1'b0;
    popped.delete();
    r4 = 1'b1;
    repeat (4) step4();
    r4 = 1'b0;
    check("drain_count", popped.size(), 4);
    for (int i = 0; i < popped.size(); i++) check("drain_order", popped[i], 32'hA0 + 32'(i));
    check("credits_back", cr4, 4);

    // Full buffer, response together with a pop
    do_reset();
    fill_full4(32'h10);
    popped.delete();
    rv4 = 1'b1; rd4 = 32'hBEEF; r4 = 1'b1;
    step4();
    rv4 = 1'b0; iv4 = 1'b1;
    repeat (5) step4();
    idle4();
    check("beef_count", popped.size(), 5);
    if (popped.size() == 5) check("beef_last", popped[4], 32'hBEEF);
    check("beef_no_overflow", of4, 0);

    // Full buffer, response without a pop
    do_reset();
    fill_full4(32'h20);
    popped.delete();
    rv4 = 1'b1; rd4 = 32'hDEAD;
    step4();
    rv4 = 1'b0;
    step4();
    check("overflow_set", of4, 1);
    repeat (3) step4();
    r4 = 1'b1;
    repeat (5) step4();
    r4 = 1'b0;
    check("overflow_sticky", of4, 1);
    check("dead_drain_count", popped.size(), 4);
    for (int i = 0; i < popped.size(); i++) check("dead_absent", popped[i] == 32'hDEAD, 0);
    do_reset();
    step4();
    check("overflow_cleared", of4, 0);

    // Response into an empty buffer with a ready consumer
    iv4 = 1'b1;
    step4();
    iv4 = 1'b0;
    rv4 = 1'b1; rd4 = 32'h55; r4 = 1'b1;
    step4();
    rv4 = 1'b0;
`ifdef LAT_CREDIT_BUFFER_FALLTHROUGH_EN
    check("ft_same_cycle_valid", last_v, 1);
    check("ft_same_cycle_data", last_d, 32'h55);
    step4();
    check("ft_next_valid", last_v, 0);
`else
    check("reg_same_cycle_valid", last_v, 0);
    step4();
    check("reg_next_valid", last_v, 1);
    check("reg_next_data", last_d, 32'h55);
`endif
    r4 = 1'b0;
    step4();
    check("ft_credits", cr4, 4);

    // Randomised traffic through a two-stage response pipeline
    do_reset();
    pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = '0; pd[1] = '0;
    for (int c = 0; c < 600; c++) begin
      rv4 = pv[1];
      rd4 = pd[1];
      iv4 = (c < 560) ? 1'($urandom_range(0, 1)) : 1'b0;
      r4  = ($urandom_range(0, 9) < 6);
      iss = iv4 && (mcred != 0);
      pv[1] = pv[0]; pd[1] = pd[0];
      pv[0] = iss;   pd[0] = $urandom;
      step4();
    end
    idle4();
    r4 = 1'b1;
    repeat (6) step4();
    check("random_final_credits", cr4, 4);
    check("random_final_overflow", of4, 0);

    // Depth=3: continuous streaming of ten items with single-cycle latency
    do_reset();
    pend_v = 1'b0; pend_d = '0; issued = 0;
    for (int c = 0; c < 40; c++) begin
      rv3 = pend_v; rd3 = pend_d;
      iv3 = (issued < 10);
      r3  = 1'b1;
      @(negedge clk);
      iss = iv3 && irdy3;
      if (v3 && r3) got3.push_back(d3);
      if (c >= 3 && c <= 9) begin
`ifdef LAT_CREDIT_BUFFER_FALLTHROUGH_EN
        check("d3_credits_steady", cr3, 2);
`else
        check("d3_credits_steady", cr3, 1);
`endif
      end
      pend_v = iss;
      pend_d = 32'(issued + 1);
      if (iss) issued++;
      @(posedge clk);
      #1;
    end
    iv3 = 1'b0; rv3 = 1'b0; r3 = 1'b0;
    check("d3_count", got3.size(), 10);
    for (int i = 0; i < got3.size(); i++) check("d3_order", got3[i], 32'(i + 1));
    check("d3_credits_final", cr3, 3);
    check("d3_overflow", of3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lat_credit_buffer.md
LAT_CREDIT_BUFFER -- requirements
Module: lat_credit_buffer

Interface
REQ-001 SHALL have parameter DataWidth, default 32, width of buffered payload.
REQ-002 SHALL have parameter Depth, default 4, buffer entries and issue credits (>= 1; elaboration error if 0).
REQ-003 SHALL have parameter CntWidth, default $clog2(Depth+1), width of credit/fill counters (derived, not overridden).
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 issue_valid_i  input  1  upstream requests to launch one item into the fixed-latency pipeline.
REQ-007 issue_ready_o  output  1  credit available; launch permitted this cycle.
REQ-008 rsp_valid_i  input  1  item emerging from the fixed-latency pipeline (shift register output); cannot be stalled.
REQ-009 rsp_data_i  input  DataWidth  payload accompanying rsp_valid_i.
REQ-010 valid_o  output  1  buffered item available downstream.
REQ-011 ready_i  input  1  downstream accepts item.
REQ-012 data_o  output  DataWidth  head-of-buffer payload.
REQ-013 credits_o  output  CntWidth  current free credits.
REQ-014 overflow_o  output  1  sticky error: response arrived with buffer full.

Function
REQ-015 Issue handshake = issue_valid_i && issue_ready_o; issue_ready_o SHALL equal (credits != 0), combinational from state only, never from issue_valid_i.
REQ-016 Pop handshake = valid_o && ready_i; valid_o SHALL equal (fill != 0) (subject to REQ-029).
REQ-017 Credit counter SHALL decrement by 1 on issue, increment by 1 on pop, hold when both or neither occur in the same cycle.
REQ-018 Credits SHALL never exceed Depth nor underflow; invariant credits + fill + in-flight == Depth.
REQ-019 Buffer SHALL be a circular FIFO of Depth entries with read/write pointers wrapping Depth-1 -> 0, including non-power-of-two Depth.
REQ-020 rsp_valid_i with fill < Depth SHALL write rsp_data_i at write pointer; fill +1.
REQ-021 Simultaneous write and pop SHALL leave fill unchanged, both pointers advance; permitted when full (pop frees slot same cycle).
REQ-022 rsp_valid_i with fill == Depth and no pop SHALL drop the item, set overflow_o, leave FIFO contents and credits unchanged.
REQ-023 overflow_o SHALL remain 1 until reset.
REQ-024 data_o SHALL hold stable while valid_o high and ready_i low.
REQ-025 Without REQ-029 feature, minimum latency rsp_valid_i -> valid_o SHALL be 1 cycle.
REQ-026 Block SHALL not depend on pipeline latency; any latency >= 0 between issue and response is correct.

Reset
REQ-027 While rst_i high at a clock edge: credits = Depth, fill = 0, pointers = 0, overflow_o = 0; valid_o = 0, issue_ready_o = 1 the following cycle.
REQ-028 Reset mid-operation SHALL discard buffered and in-flight accounting; responses arriving after reset release are counted as normal writes (upstream pipeline must be reset together).

Configuration
REQ-029 Macro LAT_CREDIT_BUFFER_FALLTHROUGH_EN defined: when fill == 0 and rsp_valid_i, valid_o = 1 and data_o = rsp_data_i same cycle; if ready_i also high item is consumed without write (fill stays 0, credit returned). Undefined: no combinational path rsp_* -> valid_o/data_o; latency per REQ-025.

Verification
REQ-030 Reset, then issue_valid_i high 6 cycles, ready_i low, Depth=4 -> exactly 4 issues accepted, issue_ready_o low from cycle 5, credits_o = 0.
REQ-031 Depth=4, 4 items in FIFO (0xA0..0xA3), ready_i high 4 cycles -> data_o order 0xA0,0xA1,0xA2,0xA3, credits_o returns 0->4.
REQ-032 Depth=3, continuous issue/response/pop 10 items (0x1..0xA) -> in-order delivery, pointer wrap, credits_o steady, overflow_o 0.
REQ-033 Fill=Depth, ready_i low, forced rsp_valid_i with 0xDEAD -> overflow_o = 1 next cycle, stays 1, 0xDEAD never on data_o.
REQ-034 Fill=Depth, rsp_valid_i with 0xBEEF and ready_i high same cycle -> no overflow, 0xBEEF delivered last.
REQ-035 With fallthrough macro, empty FIFO, rsp_valid_i=1 data 0x55, ready_i=1 -> valid_o=1, data_o=0x55 same cycle, fill stays 0; without macro -> valid_o next cycle.
